// File: rtl/nibble_add_pkg.sv
// Shared definitions for the nibble-serial adder controller: FSM state
// encodings, nibble width and the decimal-adjust constant.
package nibble_add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int         NIBBLE_W = 4;
    localparam logic [3:0] BCD_ADJ  = 4'd6;

endpackage

// File: rtl/nibble_serial_add_ctrl_adder.sv
// Four_Bit_FullAdder: plain 4-bit ripple-carry adder, the single datapath
// resource that the controller time-shares across operand nibbles.
module Four_Bit_FullAdder (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_cout
);

    logic [4:0] carry;

    always_comb begin
        carry    = '0;
        carry[0] = i_cin;
        o_sum    = '0;
        for (int i = 0; i < 4; i++) begin
            o_sum[i]     = i_a[i] ^ i_b[i] ^ carry[i];
            carry[i + 1] = (i_a[i] & i_b[i]) | (carry[i] & (i_a[i] ^ i_b[i]));
        end
    end

    assign o_cout = carry[4];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Sequences one shared 4-bit adder over NIBBLES-nibble operands, LSB first.
// Optional decimal-adjust add enabled by macro NIBBLE_ADD_BCD_MODE_EN.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for i_start; operands captured on accept
//   ST_RUN  | one nibble per clock, carry held in carry_q
//   ST_DONE | single-cycle done pulse, flags valid, then back to idle
module nibble_serial_add_ctrl
    import nibble_add_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                        i_clk,
    input  logic                        i_reset_n,
    input  logic                        i_start,
    input  logic                        i_sub,
`ifdef NIBBLE_ADD_BCD_MODE_EN
    input  logic                        i_bcd,
`endif
    input  logic [NIBBLE_W*NIBBLES-1:0] i_A,
    input  logic [NIBBLE_W*NIBBLES-1:0] i_B,
    output logic                        o_busy,
    output logic                        o_done,
    output logic [NIBBLE_W*NIBBLES-1:0] o_result,
    output logic                        o_cout,
    output logic                        o_overflow
);

    localparam int               W        = NIBBLE_W * NIBBLES;
    localparam int               IDX_W    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

    state_t           state_q, state_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     result_q, result_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             bcd_q, bcd_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [3:0] a_nib, b_nib, add_sum, nib_sum;
    logic       add_cout, nib_cout;
    logic       bcd_in;

    // Decimal adjust only applies to addition; BCD subtract falls back to binary.
`ifdef NIBBLE_ADD_BCD_MODE_EN
    assign bcd_in = i_bcd & ~i_sub;
`else
    assign bcd_in = 1'b0;
`endif

    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int n = 0; n < NIBBLES; n++) begin
            if (idx_q == IDX_W'(n)) begin
                a_nib = a_q[n*NIBBLE_W +: NIBBLE_W];
                b_nib = b_q[n*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    Four_Bit_FullAdder u_adder (
        .i_a    (a_nib),
        .i_b    (b_nib),
        .i_cin  (carry_q),
        .o_sum  (add_sum),
        .o_cout (add_cout)
    );

    always_comb begin
        nib_sum  = add_sum;
        nib_cout = add_cout;
        if (bcd_q && (add_cout || (add_sum > 4'd9))) begin
            nib_sum  = add_sum + BCD_ADJ;
            nib_cout = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        bcd_d    = bcd_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    a_d      = i_A;
                    b_d      = i_sub ? ~i_B : i_B;
                    carry_d  = i_sub;
                    bcd_d    = bcd_in;
                    idx_d    = '0;
                    result_d = '0;
                    cout_d   = 1'b0;
                    ovf_d    = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                busy_d  = 1'b1;
                carry_d = nib_cout;
                for (int n = 0; n < NIBBLES; n++) begin
                    if (idx_q == IDX_W'(n)) begin
                        result_d[n*NIBBLE_W +: NIBBLE_W] = nib_sum;
                    end
                end
                if (idx_q == IDX_LAST) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    cout_d  = nib_cout;
                    ovf_d   = ~bcd_q && (a_q[W-1] == b_q[W-1])
                              && (result_d[W-1] != a_q[W-1]);
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            bcd_q    <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            bcd_q    <= bcd_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_result   = result_q;
    assign o_cout     = cout_q;
    assign o_overflow = ovf_q;

endmodule
